hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard signal bundle between datapath and hazard controller
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           id_rs1_i;
    logic [4:0]           id_rs2_i;
    logic                 id_uses_rs1_i;
    logic                 id_uses_rs2_i;
    logic [4:0]           ex_rd_i;
    logic                 ex_mem_read_i;
    logic                 ex_branch_taken_i;
    logic                 mem_busy_i;
    logic                 cnt_clr_i;
    logic                 pc_en_o;
    logic                 q1q2_en_o;
    logic                 q2q3_en_o;
    logic                 q1q2_flush_o;
    logic                 q2q3_flush_o;
    logic [1:0]           state_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, mem_busy_i, cnt_clr_i,
        input  pc_en_o, q1q2_en_o, q2q3_en_o, q1q2_flush_o, q2q3_flush_o,
               state_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i, ex_rd_i,
               ex_mem_read_i, ex_branch_taken_i, mem_busy_i, cnt_clr_i,
        output pc_en_o, q1q2_en_o, q2q3_en_o, q1q2_flush_o, q2q3_flush_o,
               state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 3-stage pipeline stall/flush controller with performance counters
module hazard_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [3:0]           flush_left, flush_left_n;
    logic                 flush_pend, flush_pend_n;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    logic load_use;
    logic branch_req;
    logic pc_en, q1q2_en, q2q3_en, q1q2_flush, q2q3_flush;

    assign load_use = hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0) &&
                      ((hz.id_uses_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                       (hz.id_uses_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));

    // A branch seen while memory was stalled is replayed once memory frees up.
    assign branch_req = hz.ex_branch_taken_i || ((state == MEM_WAIT) && flush_pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_left <= 4'd0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_n;
            flush_left <= flush_left_n;
            flush_pend <= flush_pend_n;
        end
    end

    always_comb begin
        state_n      = state;
        flush_left_n = flush_left;
        flush_pend_n = flush_pend;
        case (state)
            RUN, MEM_WAIT: begin
                if (hz.mem_busy_i) begin
                    state_n      = MEM_WAIT;
                    flush_pend_n = (state == MEM_WAIT) ? (flush_pend || hz.ex_branch_taken_i)
                                                       : hz.ex_branch_taken_i;
                end else begin
                    flush_pend_n = 1'b0;
                    state_n      = RUN;
                    if (branch_req && (BRANCH_PENALTY > 1)) begin
                        state_n      = FLUSH;
                        flush_left_n = 4'(BRANCH_PENALTY - 1);
                    end
                end
            end
            FLUSH: begin
                if (!hz.mem_busy_i) begin
                    flush_left_n = flush_left - 4'd1;
                    if (flush_left <= 4'd1) begin
                        state_n = RUN;
                    end
                end
            end
            default: begin
                state_n      = RUN;
                flush_left_n = 4'd0;
                flush_pend_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        q1q2_en    = 1'b0;
        q2q3_en    = 1'b0;
        q1q2_flush = 1'b0;
        q2q3_flush = 1'b0;
        if (!rst) begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (!hz.mem_busy_i) begin
                        if (branch_req) begin
                            {pc_en, q1q2_en, q2q3_en, q1q2_flush, q2q3_flush} = 5'b11111;
                        end else if (load_use) begin
                            q2q3_en    = 1'b1;
                            q2q3_flush = 1'b1;
                        end else begin
                            {pc_en, q1q2_en, q2q3_en} = 3'b111;
                        end
                    end
                end
                FLUSH: begin
                    if (!hz.mem_busy_i) begin
                        {pc_en, q1q2_en, q2q3_en, q1q2_flush, q2q3_flush} = 5'b11111;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear beats increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || hz.cnt_clr_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (q1q2_flush && (flush_cnt != {CNT_WIDTH{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hz.pc_en_o      = pc_en;
    assign hz.q1q2_en_o    = q1q2_en;
    assign hz.q2q3_en_o    = q2q3_en;
    assign hz.q1q2_flush_o = q1q2_flush;
    assign hz.q2q3_flush_o = q2q3_flush;
    assign hz.state_o      = rst ? RUN : state;
    assign hz.stall_cnt_o  = rst ? '0 : stall_cnt;
    assign hz.flush_cnt_o  = rst ? '0 : flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with two parameterisations
module tb_hazard_ctrl;
    localparam logic [4:0] C_RUN = 5'b11100;
    localparam logic [4:0] C_BR  = 5'b11111;
    localparam logic [4:0] C_BUB = 5'b00101;
    localparam logic [4:0] C_FRZ = 5'b00000;

    typedef struct {
        string      name;
        bit         d;
        logic [4:0] ctl;
        logic [1:0] st;
        int         sc;
        int         fc;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    hazard_ctrl_if #(.CNT_WIDTH(4)) bus_a ();
    hazard_ctrl_if #(.CNT_WIDTH(8)) bus_b ();

    hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_WIDTH(4)) dut_a (.clk(clk), .rst(rst), .hz(bus_a));
    hazard_ctrl #(.BRANCH_PENALTY(3), .CNT_WIDTH(8)) dut_b (.clk(clk), .rst(rst), .hz(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input bit busy, input bit br, input int lu, input bit clr);
        bus_a.id_rs1_i          = 5'd3;
        bus_a.id_uses_rs1_i     = 1'b1;
        bus_a.id_rs2_i          = (lu == 2) ? 5'd0 : 5'd5;
        bus_a.id_uses_rs2_i     = 1'b1;
        bus_a.ex_rd_i           = (lu == 2) ? 5'd0 : 5'd5;
        bus_a.ex_mem_read_i     = (lu != 0);
        bus_a.ex_branch_taken_i = br;
        bus_a.mem_busy_i        = busy;
        bus_a.cnt_clr_i         = clr;
        bus_b.id_rs1_i          = bus_a.id_rs1_i;
        bus_b.id_uses_rs1_i     = bus_a.id_uses_rs1_i;
        bus_b.id_rs2_i          = bus_a.id_rs2_i;
        bus_b.id_uses_rs2_i     = bus_a.id_uses_rs2_i;
        bus_b.ex_rd_i           = bus_a.ex_rd_i;
        bus_b.ex_mem_read_i     = bus_a.ex_mem_read_i;
        bus_b.ex_branch_taken_i = br;
        bus_b.mem_busy_i        = busy;
        bus_b.cnt_clr_i         = clr;
    endtask

    task automatic cyc(input string nm, input bit d, input bit r, input bit busy, input bit br,
                       input int lu, input bit clr, input logic [4:0] ctl, input logic [1:0] st,
                       input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        set_in(busy, br, lu, clr);
        e.name = nm;
        e.d    = d;
        e.ctl  = ctl;
        e.st   = st;
        e.sc   = sc;
        e.fc   = fc;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [4:0] ctl;
        logic [1:0] st;
        int         sc;
        int         fc;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (!e.d) begin
                    ctl = {bus_a.pc_en_o, bus_a.q1q2_en_o, bus_a.q2q3_en_o,
                           bus_a.q1q2_flush_o, bus_a.q2q3_flush_o};
                    st  = bus_a.state_o;
                    sc  = {28'd0, bus_a.stall_cnt_o};
                    fc  = {28'd0, bus_a.flush_cnt_o};
                end else begin
                    ctl = {bus_b.pc_en_o, bus_b.q1q2_en_o, bus_b.q2q3_en_o,
                           bus_b.q1q2_flush_o, bus_b.q2q3_flush_o};
                    st  = bus_b.state_o;
                    sc  = {24'd0, bus_b.stall_cnt_o};
                    fc  = {24'd0, bus_b.flush_cnt_o};
                end
                n_chk++;
                if (ctl === e.ctl && st === e.st && sc == e.sc && fc == e.fc) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got ctl=%b st=%0d stall=%0d flush=%0d, want ctl=%b st=%0d stall=%0d flush=%0d",
                             e.name, ctl, st, sc, fc, e.ctl, e.st, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        rst = 1'b1;
        set_in(0, 0, 0, 0);

        // design A: BRANCH_PENALTY=2, CNT_WIDTH=4
        cyc("reset0",     0, 1, 0, 0, 0, 0, C_FRZ, 2'd0, 0, 0);
        cyc("reset1",     0, 1, 0, 0, 0, 0, C_FRZ, 2'd0, 0, 0);
        cyc("idle",       0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc("load_use",   0, 0, 0, 0, 1, 0, C_BUB, 2'd0, 0, 0);
        cyc("after_lu",   0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 1, 0);
        cyc("x0_nohaz",   0, 0, 0, 0, 2, 0, C_RUN, 2'd0, 1, 0);
        cyc("branch",     0, 0, 0, 1, 0, 0, C_BR,  2'd0, 1, 0);
        cyc("flush1",     0, 0, 0, 0, 0, 0, C_BR,  2'd2, 1, 1);
        cyc("post_br",    0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 1, 2);
        cyc("clr",        0, 0, 0, 0, 0, 1, C_RUN, 2'd0, 1, 2);
        cyc("after_clr",  0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc("busy_br",    0, 0, 1, 1, 0, 0, C_FRZ, 2'd0, 0, 0);
        cyc("busy2",      0, 0, 1, 0, 0, 0, C_FRZ, 2'd1, 1, 0);
        cyc("busy3",      0, 0, 1, 0, 0, 0, C_FRZ, 2'd1, 2, 0);
        cyc("pend_br",    0, 0, 0, 0, 0, 0, C_BR,  2'd1, 3, 0);
        cyc("pend_fl",    0, 0, 0, 0, 0, 0, C_BR,  2'd2, 3, 1);
        cyc("pend_done",  0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 3, 2);
        for (int k = 0; k < 20; k++) begin
            cyc("sat_lu", 0, 0, 0, 0, 1, 0, C_BUB, 2'd0, (3 + k > 15) ? 15 : 3 + k, 2);
        end
        cyc("sat_hold",   0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 15, 2);
        cyc("clr_vs_inc", 0, 0, 0, 0, 1, 1, C_BUB, 2'd0, 15, 2);
        cyc("clr_won",    0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc("br_pre_rst", 0, 0, 0, 1, 0, 0, C_BR,  2'd0, 0, 0);
        cyc("rst_flush",  0, 1, 0, 0, 0, 0, C_FRZ, 2'd0, 0, 0);
        cyc("rst_out1",   0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc("rst_out2",   0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc("mw_pre_rst", 0, 0, 1, 1, 0, 0, C_FRZ, 2'd0, 0, 0);
        cyc("rst_mw",     0, 1, 0, 0, 0, 0, C_FRZ, 2'd0, 0, 0);
        cyc("mw_out1",    0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc("mw_out2",    0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);

        // design B: BRANCH_PENALTY=3, CNT_WIDTH=8
        cyc("b_reset",    1, 1, 0, 0, 0, 0, C_FRZ, 2'd0, 0, 0);
        cyc("b_idle",     1, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc("b_branch",   1, 0, 0, 1, 0, 0, C_BR,  2'd0, 0, 0);
        cyc("b_busy1",    1, 0, 1, 0, 0, 0, C_FRZ, 2'd2, 0, 1);
        cyc("b_busy2",    1, 0, 1, 1, 1, 0, C_FRZ, 2'd2, 1, 1);
        cyc("b_flush2",   1, 0, 0, 1, 1, 0, C_BR,  2'd2, 2, 1);
        cyc("b_flush3",   1, 0, 0, 0, 0, 0, C_BR,  2'd2, 2, 2);
        cyc("b_run",      1, 0, 0, 0, 0, 0, C_RUN, 2'd0, 2, 3);
        cyc("b_busy_nb",  1, 0, 1, 0, 0, 0, C_FRZ, 2'd0, 2, 3);
        cyc("b_mw_lu",    1, 0, 0, 0, 1, 0, C_BUB, 2'd1, 3, 3);
        cyc("b_end",      1, 0, 0, 0, 0, 0, C_RUN, 2'd0, 4, 3);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries unchecked, want 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
